i2c_line_driver: RTL and testbench
==================================

# i2c_line_driver

Bit-level I2C line driver: the transmit side of the I2C pad path, paired with the receive-side input filter. It turns single bus commands (START, STOP, WRITE bit, READ bit) into timed open-drain enable sequences on SCL/SDA. It also samples the filtered bus lines to read bits, honour slave clock stretching and detect arbitration loss. It sits between the byte controller and the pad buffers. Its scl_i/sda_i inputs come from the filter's stable signal outputs.

## Interface
- (no parameters)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  core enable; low aborts any command
- clk_cnt  in  16  phase prescale; each phase lasts clk_cnt+1 cycles
- cmd  in  3  001 START, 010 STOP, 011 WRITE, 100 READ; other codes ignored
- cmd_valid  in  1  command request
- din  in  1  bit to write; latched on acceptance
- scl_i  in  1  filtered SCL level
- sda_i  in  1  filtered SDA level
- cmd_ack  out  1  one-cycle pulse: command completed
- dout  out  1  bit sampled by last READ
- busy  out  1  command in progress
- al  out  1  one-cycle pulse: arbitration lost
- scl_oen  out  1  SCL output enable, active-low (0 = pull low, 1 = release)
- sda_oen  out  1  SDA output enable, active-low

## Operation
- Reset values: scl_oen=1, sda_oen=1, cmd_ack=0, al=0, busy=0, dout=0, state IDLE, timer=0.
- Acceptance:
  - A command is accepted at a clk edge where state=IDLE, ena=1, cmd_valid=1 and cmd is a legal code.
  - The acceptance edge latches din, enters phase A and loads timer=clk_cnt.
  - Illegal codes are never accepted and produce no ack.
- Each command runs four phases A–D. Line values are given as (sda_oen, scl_oen):
  - START: A (1, keep previous scl_oen), B (1,1), C (0,1), D (0,0).
  - STOP: A (0,0), B (0,1), C (0,1), D (1,1).
  - WRITE: A (din,0), B (din,1), C (din,1), D (din,0).
  - READ: A (1,0), B (1,1), C (1,1), D (1,0). dout<=sda_i on the edge that ends phase C.
- Timer and phase progression:
  - The timer decrements each cycle. When it reaches 0, the next edge advances the phase and reloads clk_cnt.
  - clk_cnt is resampled at every reload.
- Clock stretching: while scl_oen=1 and scl_i=0, the timer holds its value and the phase does not advance.
- Completion: the edge ending phase D returns the block to IDLE and asserts cmd_ack for one cycle. busy is 0 from that edge.
- Arbitration loss:
  - Condition: a WRITE with latched din=1, and sda_i=0 on the edge ending phase B or C.
  - On that edge: al=1 for one cycle, state goes to IDLE, scl_oen=1, sda_oen=1, busy=0, no cmd_ack.
- ena low:
  - On any edge with ena=0 the block behaves like the arbitration-loss exit, except al stays 0.
  - Commands are not accepted while ena=0.
- rst has priority over ena, al and everything else.

## Timing
- All outputs are registered. Line enables change on the edge that enters a phase.
- busy=1 from the acceptance edge until the completion or abort edge.
- Unstretched command length: 4·(clk_cnt+1) cycles from acceptance to the ack edge.
- With clk_cnt=0, each phase lasts 1 cycle and a command takes 4 cycles.
- Back-to-back commands:
  - A command presented during the cmd_ack cycle is accepted on the next edge, because state is IDLE then.
  - The minimum gap between commands is one idle cycle.
- Stretch latency: the filter delay on scl_i lengthens phase B by that delay. This is accepted behaviour.
- If the bus sits low in phase B, the command waits indefinitely. Only ena=0 or rst exits this state.
- Reset mid-command: on the next edge the block is in IDLE with reset values. No ack and no al are produced.

## Test plan
- clk_cnt=3, START then STOP, scl_i=sda_i follow the enables → each phase lasts 4 cycles; (sda_oen,scl_oen) sequences match the Operation table; cmd_ack at cycle 16 after each acceptance; busy low in the ack cycle.
- clk_cnt=1, WRITE din=0 then din=1 → sda_oen=0 then 1 across all four phases; SCL pulses high during B–C; each command takes 8 cycles; al=0.
- clk_cnt=2, READ with sda_i=0 at end of phase C → dout=0 after the C→D edge; cmd_ack 12 cycles after acceptance. Repeat with sda_i=1 → dout=1.
- clk_cnt=3, WRITE, scl_i held 0 for 10 cycles after phase B entry → phase B is extended by exactly 10 cycles; cmd_ack at cycle 26.
- WRITE din=1, sda_i forced 0 during phase B → al pulses one cycle at the end of B; scl_oen=1 and sda_oen=1; no cmd_ack; busy=0.
- ena dropped mid-READ, then rst pulsed mid-WRITE → both abort to IDLE with lines released and no ack or al. A subsequent START with ena=1 completes normally.

Source files
------------

// File: rtl/i2c_line_driver.sv
// I2C bit-level line driver: turns START/STOP/WRITE/READ into four timed open-drain phases.
// Each phase lasts clk_cnt+1 cycles; a released SCL held low by a slave freezes the phase.
module i2c_line_driver (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [15:0] clk_cnt,
   input  logic [2:0]  cmd,
   input  logic        cmd_valid,
   input  logic        din,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        cmd_ack,
   output logic        dout,
   output logic        busy,
   output logic        al,
   output logic        scl_oen,
   output logic        sda_oen
);

   localparam logic [2:0] CMD_START = 3'b001;
   localparam logic [2:0] CMD_STOP  = 3'b010;
   localparam logic [2:0] CMD_WRITE = 3'b011;
   localparam logic [2:0] CMD_READ  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_A,
      ST_B,
      ST_C,
      ST_D
   } state_t;

   state_t      state_q, state_d;
   state_t      phase_nxt;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  cmd_q, cmd_d;
   logic        din_q, din_d;
   logic        scl_oen_q, scl_oen_d;
   logic        sda_oen_q, sda_oen_d;
   logic        ack_q, ack_d;
   logic        al_q, al_d;
   logic        busy_q, busy_d;
   logic        dout_q, dout_d;
   logic        stretch;
   logic        legal_cmd;
   logic        lost;

   // Returns {sda_oen, scl_oen} to drive while in phase ph of command c.
   function automatic logic [1:0] phase_lines(input logic [2:0] c, input state_t ph,
                                              input logic d, input logic scl_prev);
      logic [1:0] l;
      l = 2'b11;
      case (c)
         CMD_START: begin
            case (ph)
               ST_A:    l = {1'b1, scl_prev};
               ST_B:    l = 2'b11;
               ST_C:    l = 2'b01;
               ST_D:    l = 2'b00;
               default: l = 2'b11;
            endcase
         end
         CMD_STOP: begin
            case (ph)
               ST_A:    l = 2'b00;
               ST_B:    l = 2'b01;
               ST_C:    l = 2'b01;
               ST_D:    l = 2'b11;
               default: l = 2'b11;
            endcase
         end
         CMD_WRITE: begin
            case (ph)
               ST_A:    l = {d, 1'b0};
               ST_B:    l = {d, 1'b1};
               ST_C:    l = {d, 1'b1};
               ST_D:    l = {d, 1'b0};
               default: l = 2'b11;
            endcase
         end
         CMD_READ: begin
            case (ph)
               ST_A:    l = 2'b10;
               ST_B:    l = 2'b11;
               ST_C:    l = 2'b11;
               ST_D:    l = 2'b10;
               default: l = 2'b11;
            endcase
         end
         default: l = 2'b11;
      endcase
      return l;
   endfunction

   assign legal_cmd = (cmd == CMD_START) || (cmd == CMD_STOP) ||
                      (cmd == CMD_WRITE) || (cmd == CMD_READ);
   assign stretch   = scl_oen_q && !scl_i;
   // Only a driven-high SDA that reads back low counts as a lost bus.
   assign lost      = (cmd_q == CMD_WRITE) && din_q && !sda_i &&
                      ((state_q == ST_B) || (state_q == ST_C));

   always_comb begin
      phase_nxt = ST_D;
      case (state_q)
         ST_A:    phase_nxt = ST_B;
         ST_B:    phase_nxt = ST_C;
         ST_C:    phase_nxt = ST_D;
         default: phase_nxt = ST_D;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      cmd_d     = cmd_q;
      din_d     = din_q;
      scl_oen_d = scl_oen_q;
      sda_oen_d = sda_oen_q;
      ack_d     = 1'b0;
      al_d      = 1'b0;
      busy_d    = busy_q;
      dout_d    = dout_q;

      if (!ena) begin
         state_d   = ST_IDLE;
         scl_oen_d = 1'b1;
         sda_oen_d = 1'b1;
         busy_d    = 1'b0;
      end else if (state_q == ST_IDLE) begin
         if (cmd_valid && legal_cmd) begin
            state_d                = ST_A;
            cmd_d                  = cmd;
            din_d                  = din;
            timer_d                = clk_cnt;
            busy_d                 = 1'b1;
            {sda_oen_d, scl_oen_d} = phase_lines(cmd, ST_A, din, scl_oen_q);
         end
      end else if (stretch) begin
         state_d = state_q;
      end else if (timer_q != 16'd0) begin
         timer_d = timer_q - 16'd1;
      end else if (lost) begin
         state_d   = ST_IDLE;
         scl_oen_d = 1'b1;
         sda_oen_d = 1'b1;
         busy_d    = 1'b0;
         al_d      = 1'b1;
      end else if (state_q == ST_D) begin
         state_d = ST_IDLE;
         ack_d   = 1'b1;
         busy_d  = 1'b0;
      end else begin
         state_d                = phase_nxt;
         timer_d                = clk_cnt;
         {sda_oen_d, scl_oen_d} = phase_lines(cmd_q, phase_nxt, din_q, scl_oen_q);
         if ((cmd_q == CMD_READ) && (state_q == ST_C)) begin
            dout_d = sda_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= 16'd0;
         cmd_q     <= 3'b000;
         din_q     <= 1'b0;
         scl_oen_q <= 1'b1;
         sda_oen_q <= 1'b1;
         ack_q     <= 1'b0;
         al_q      <= 1'b0;
         busy_q    <= 1'b0;
         dout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cmd_q     <= cmd_d;
         din_q     <= din_d;
         scl_oen_q <= scl_oen_d;
         sda_oen_q <= sda_oen_d;
         ack_q     <= ack_d;
         al_q      <= al_d;
         busy_q    <= busy_d;
         dout_q    <= dout_d;
      end
   end

   assign cmd_ack = ack_q;
   assign al      = al_q;
   assign busy    = busy_q;
   assign dout    = dout_q;
   assign scl_oen = scl_oen_q;
   assign sda_oen = sda_oen_q;

endmodule

// File: tb/tb_i2c_line_driver.sv
// Bench for i2c_line_driver: directed plan items plus randomized command streams,
// compared cycle by cycle against a phase-length timeline model of the bus.
module tb_i2c_line_driver;

   localparam logic [2:0] C_START = 3'b001;
   localparam logic [2:0] C_STOP  = 3'b010;
   localparam logic [2:0] C_WRITE = 3'b011;
   localparam logic [2:0] C_READ  = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [15:0] clk_cnt;
   logic [2:0]  cmd;
   logic        cmd_valid;
   logic        din;
   logic        scl_i;
   logic        sda_i;
   logic        cmd_ack;
   logic        dout;
   logic        busy;
   logic        al;
   logic        scl_oen;
   logic        sda_oen;

   logic        scl_force = 1'b0;
   logic        slave_sda = 1'b1;
   logic        exp_sda   = 1'b1;
   logic        exp_scl   = 1'b1;
   logic        exp_dout  = 1'b0;
   int          n_checks  = 0;
   int          n_errors  = 0;

   i2c_line_driver dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .clk_cnt   (clk_cnt),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .din       (din),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .cmd_ack   (cmd_ack),
      .dout      (dout),
      .busy      (busy),
      .al        (al),
      .scl_oen   (scl_oen),
      .sda_oen   (sda_oen)
   );

   always #5 clk = ~clk;

   // Wired-AND bus: the slave side can only pull lines low.
   assign scl_i = scl_oen & ~scl_force;
   assign sda_i = sda_oen & slave_sda;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string t, input logic e_sda, input logic e_scl, input logic e_busy,
                          input logic e_ack, input logic e_al, input logic e_dout);
      chk({t, ".sda_oen"}, sda_oen, e_sda);
      chk({t, ".scl_oen"}, scl_oen, e_scl);
      chk({t, ".busy"}, busy, e_busy);
      chk({t, ".cmd_ack"}, cmd_ack, e_ack);
      chk({t, ".al"}, al, e_al);
      chk({t, ".dout"}, dout, e_dout);
   endtask

   // Bus-level waveform each command must produce, as {sda_oen, scl_oen} per phase.
   function automatic logic [1:0] lines_of(input logic [2:0] c, input int p, input logic d,
                                           input logic ps);
      logic [1:0] tbl [4];
      case (c)
         C_START: tbl = '{{1'b1, ps}, 2'b11, 2'b01, 2'b00};
         C_STOP:  tbl = '{2'b00, 2'b01, 2'b01, 2'b11};
         C_WRITE: tbl = '{{d, 1'b0}, {d, 1'b1}, {d, 1'b1}, {d, 1'b0}};
         default: tbl = '{2'b10, 2'b11, 2'b11, 2'b10};
      endcase
      return tbl[p];
   endfunction

   // s = cycles SCL is held low from phase B entry; lose = slave pulls SDA low during B.
   task automatic run_cmd(input logic [2:0] c, input logic d, input int n, input int s,
                          input logic rb, input logic lose);
      int         len [4];
      int         p;
      int         t;
      int         tot;
      logic       ps;
      logic [1:0] ln;
      string      tag;
      ps        = exp_scl;
      clk_cnt   = 16'(n);
      cmd       = c;
      din       = d;
      cmd_valid = 1'b1;
      slave_sda = (c == C_READ) ? rb : 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      din       = ~d;
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         len[i] = n + 1 + ((i == 1) ? s : 0);
         tot += len[i];
      end
      for (int k = 0; k <= tot; k++) begin
         p = 0;
         t = k;
         while (p < 4 && t >= len[p]) begin
            t -= len[p];
            p++;
         end
         tag = $sformatf("c%0d n%0d s%0d k%0d", c, n, s, k);
         if (lose && k == 2 * (n + 1)) begin
            chk_all({tag, " al_exit"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_dout);
            exp_sda = 1'b1;
            exp_scl = 1'b1;
            break;
         end
         if (p == 4) begin
            ln = lines_of(c, 3, d, ps);
            chk_all({tag, " ack"}, ln[1], ln[0], 1'b0, 1'b1, 1'b0, exp_dout);
            exp_sda = ln[1];
            exp_scl = ln[0];
            break;
         end
         if (c == C_READ && p == 3) exp_dout = rb;
         ln = lines_of(c, p, d, ps);
         chk_all({tag, " phase"}, ln[1], ln[0], 1'b1, 1'b0, 1'b0, exp_dout);
         scl_force = (k >= n + 1) && (k <= n + s);
         if (lose && k >= n + 1) slave_sda = 1'b0;
         @(posedge clk);
         #1;
      end
      scl_force = 1'b0;
      slave_sda = 1'b1;
   endtask

   task automatic idle(input int g);
      repeat (g) begin
         @(posedge clk);
         #1;
         chk_all("idle", exp_sda, exp_scl, 1'b0, 1'b0, 1'b0, exp_dout);
      end
   endtask

   task automatic illegal_cmd(input logic [2:0] c);
      cmd       = c;
      din       = 1'b1;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk_all($sformatf("illegal%0d", c), exp_sda, exp_scl, 1'b0, 1'b0, 1'b0, exp_dout);
   endtask

   task automatic abort_cmd(input logic [2:0] c, input logic d, input int n, input int m,
                            input logic use_rst);
      clk_cnt   = 16'(n);
      cmd       = c;
      din       = d;
      cmd_valid = 1'b1;
      slave_sda = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (m) begin
         @(posedge clk);
         #1;
      end
      chk("abort.pre_busy", busy, 1'b1);
      if (use_rst) rst = 1'b1;
      else ena = 1'b0;
      @(posedge clk);
      #1;
      if (use_rst) exp_dout = 1'b0;
      chk_all(use_rst ? "rst_exit" : "ena_exit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_dout);
      exp_sda = 1'b1;
      exp_scl = 1'b1;
      if (!use_rst) begin
         cmd       = C_START;
         cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         chk_all("ena_low_noaccept", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_dout);
      end
      rst = 1'b0;
      ena = 1'b1;
      idle(1);
   endtask

   initial begin
      logic [2:0] c;
      logic       d;
      logic       rb;
      logic       lose;
      int         n;
      int         s;
      rst       = 1'b1;
      ena       = 1'b1;
      cmd       = 3'b000;
      cmd_valid = 1'b0;
      din       = 1'b0;
      clk_cnt   = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(1);

      run_cmd(C_START, 1'b0, 3, 0, 1'b1, 1'b0);
      run_cmd(C_STOP, 1'b0, 3, 0, 1'b1, 1'b0);
      idle(1);
      run_cmd(C_WRITE, 1'b0, 1, 0, 1'b1, 1'b0);
      run_cmd(C_WRITE, 1'b1, 1, 0, 1'b1, 1'b0);
      run_cmd(C_READ, 1'b0, 2, 0, 1'b0, 1'b0);
      run_cmd(C_READ, 1'b0, 2, 0, 1'b1, 1'b0);
      run_cmd(C_WRITE, 1'b1, 3, 10, 1'b1, 1'b0);
      idle(1);
      run_cmd(C_WRITE, 1'b1, 2, 0, 1'b1, 1'b1);
      idle(2);
      abort_cmd(C_READ, 1'b0, 2, 4, 1'b0);
      abort_cmd(C_WRITE, 1'b1, 2, 5, 1'b1);
      run_cmd(C_START, 1'b0, 1, 0, 1'b1, 1'b0);
      illegal_cmd(3'b000);
      illegal_cmd(3'b111);
      idle(2);

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            c = 3'($urandom_range(4, 7));
            if (c == 3'b100) c = 3'b000;
            illegal_cmd(c);
         end
         c    = 3'($urandom_range(1, 4));
         d    = 1'($urandom);
         rb   = 1'($urandom);
         n    = $urandom_range(0, 3);
         s    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
         lose = (c == C_WRITE) && d && ($urandom_range(0, 3) == 0);
         if (lose) s = 0;
         run_cmd(c, d, n, s, rb, lose);
         idle(lose ? 1 : $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
